// File: rtl/max7219_tx_pkg.sv
// Shared definitions for the MAX7219 serial transmitter: register map,
// FSM state encoding and frame packing.
package max7219_tx_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIG0      = 8'h01;
  localparam logic [7:0] REG_DIG1      = 8'h02;
  localparam logic [7:0] REG_DIG2      = 8'h03;
  localparam logic [7:0] REG_DIG3      = 8'h04;
  localparam logic [7:0] REG_DIG4      = 8'h05;
  localparam logic [7:0] REG_DIG5      = 8'h06;
  localparam logic [7:0] REG_DIG6      = 8'h07;
  localparam logic [7:0] REG_DIG7      = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [15:0] make_frame(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/max7219_tx_if.sv
// Upstream request handshake plus the three-wire MAX7219 serial link.
interface max7219_tx_if;
  logic [7:0] addr_in;
  logic [7:0] din;
  logic       start;
  logic       busy;
  logic       done;
  logic       sck;
  logic       dout;
  logic       load;

  modport master (output addr_in, din, start, input busy, done, sck, dout, load);
  modport slave  (input addr_in, din, start, output busy, done, sck, dout, load);
endinterface

// File: rtl/max7219_sck_div.sv
// Half-period tick generator: tick marks the last cycle of each sck half-period.
module max7219_sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Held at zero while disabled so every frame starts on a fresh half-period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                div_cnt <= '0;
    else if (!en || div_cnt == LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + CW'(1);
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/max7219_tx.sv
// MAX7219 transmitter: latches one {addr, data} word per handshake and shifts
// it MSB first on dout/sck inside a low load window.
module max7219_tx
  import max7219_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic         clock,
  input logic         reset,
  max7219_tx_if.slave bus
);

  state_t      state, state_n;
  logic [15:0] shreg, shreg_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        sck_q, sck_n;
  logic        done_n, busy_n, load_n, dout_n;
  logic        tick;

  max7219_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .en    (state != IDLE),
    .tick  (tick)
  );

  always_comb begin
    // NOTE: every target gets a default first, so no branch can infer a latch.
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    sck_n     = sck_q;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        sck_n = 1'b0;
        if (bus.start) begin
          state_n   = SHIFT;
          shreg_n   = make_frame(bus.addr_in, bus.din);
          bit_cnt_n = 4'd0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sck_q) begin
            sck_n = 1'b1;
          end else begin
            sck_n     = 1'b0;
            shreg_n   = {shreg[14:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_n = HOLD;
          end
        end
      end
      HOLD: begin
        sck_n = 1'b0;
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Outputs are derived from next-state values so they can be registered.
    busy_n = (state_n != IDLE);
    load_n = (state_n != SHIFT);
    dout_n = (state_n == SHIFT) ? shreg_n[15] : 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is reset as well; its content is don't-care in IDLE
      // but a defined value keeps dout free of X after reset.
      shreg    <= '0;
      bit_cnt  <= '0;
      sck_q    <= 1'b0;
      bus.dout <= 1'b0;
      bus.load <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      sck_q    <= sck_n;
      bus.dout <= dout_n;
      bus.load <= load_n;
      bus.busy <= busy_n;
      bus.done <= done_n;
    end
  end

  assign bus.sck = sck_q;

endmodule

// File: tb/tb_max7219_tx.sv
// Self-checking bench for max7219_tx: a behavioural MAX7219 receiver per DUT
// (CLK_DIV=2 and CLK_DIV=1) plus directed vectors and hand-written sequences.
module tb_max7219_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] data  = 8'h00;
  logic       start2 = 1'b0;
  logic       start1 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  max7219_tx_if bus2();
  max7219_tx_if bus1();

  assign bus2.addr_in = addr;
  assign bus2.din     = data;
  assign bus2.start   = start2;
  assign bus1.addr_in = addr;
  assign bus1.din     = data;
  assign bus1.start   = start1;

  max7219_tx #(.CLK_DIV(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  max7219_tx #(.CLK_DIV(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // MAX7219 receiver models: sample on sck rise, latch a full word on load rise.
  logic [15:0] sh2 = '0, sh1 = '0;
  int          nb2 = 0, nb1 = 0;
  int          edge_viol = 0;
  logic [15:0] fq2[$];
  logic [15:0] fq1[$];

  always @(posedge bus2.sck) begin
    if (bus2.load !== 1'b0) edge_viol++;
    sh2 = {sh2[14:0], bus2.dout};
    nb2++;
  end
  always @(negedge bus2.load) nb2 = 0;
  always @(posedge bus2.load) if (nb2 == 16) fq2.push_back(sh2);

  always @(posedge bus1.sck) begin
    if (bus1.load !== 1'b0) edge_viol++;
    sh1 = {sh1[14:0], bus1.dout};
    nb1++;
  end
  always @(negedge bus1.load) nb1 = 0;
  always @(posedge bus1.load) if (nb1 == 16) fq1.push_back(sh1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 2) ? bus2.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 2) ? bus2.done : bus1.done;
  endfunction

  function automatic logic get_sck(input int sel);
    return (sel == 2) ? bus2.sck : bus1.sck;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 2) start2 = v;
    else          start1 = v;
  endtask

  // Wait (on negedges) until busy equals val; a timeout counts as a failure.
  task automatic wait_busy(input int sel, input logic val, input string name);
    int n;
    n = 0;
    while (get_busy(sel) !== val && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check({name, "_timeout"}, 32'(get_busy(sel)), 32'(val));
  endtask

  // One complete frame with cycle-exact busy/done/sck accounting.
  task automatic send(input int sel, input int cdiv, input logic [7:0] a,
                      input logic [7:0] d, input string name);
    int bc, sc, dn;
    @(negedge clock);
    addr = a;
    data = d;
    set_start(sel, 1'b1);
    @(negedge clock);
    set_start(sel, 1'b0);
    addr = 8'h5A;
    data = 8'hC3;
    bc = 0; sc = 0; dn = 0;
    while (get_busy(sel) === 1'b1 && bc < 400) begin
      bc++;
      if (get_sck(sel) === 1'b1) sc++;
      if (get_done(sel) === 1'b1) dn++;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, 32'(bc), 32'(33 * cdiv));
    check({name, "_sck_high_cycles"}, 32'(sc), 32'(16 * cdiv));
    check({name, "_done_while_busy"}, 32'(dn), 32'd0);
    check({name, "_done_pulse"}, 32'(get_done(sel)), 32'd1);
    @(negedge clock);
    check({name, "_done_cleared"}, 32'(get_done(sel)), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] exp;
  } vec_t;

  vec_t held[3];
  vec_t digits[8];

  initial begin
    held[0] = '{8'h0A, 8'h03, 16'h0A03};
    held[1] = '{8'h09, 8'hFF, 16'h09FF};
    held[2] = '{8'h0B, 8'h07, 16'h0B07};
    digits[0] = '{8'h01, 8'h3F, 16'h013F};
    digits[1] = '{8'h02, 8'h06, 16'h0206};
    digits[2] = '{8'h03, 8'h5B, 16'h035B};
    digits[3] = '{8'h04, 8'h4F, 16'h044F};
    digits[4] = '{8'h05, 8'h66, 16'h0566};
    digits[5] = '{8'h06, 8'h6D, 16'h066D};
    digits[6] = '{8'h07, 8'h80, 16'h0780};
    digits[7] = '{8'h08, 8'h01, 16'h0801};

    // 1: reset held with start asserted
    addr = 8'h0C; data = 8'h01; start2 = 1'b1; start1 = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_load", 32'(bus2.load), 32'd1);
    check("rst_sck", 32'(bus2.sck), 32'd0);
    check("rst_dout", 32'(bus2.dout), 32'd0);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_done", 32'(bus2.done), 32'd0);
    check("rst_busy_div1", 32'(bus1.busy), 32'd0);
    start2 = 1'b0; start1 = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_no_accept", 32'(bus2.busy), 32'd0);
    check("rst_no_frame", 32'(fq2.size()), 32'd0);

    // 2: single frame at CLK_DIV=2
    fq2.delete();
    send(2, 2, 8'h0C, 8'h01, "single");
    check("single_count", 32'(fq2.size()), 32'd1);
    if (fq2.size() > 0) check("single_word", 32'(fq2[0]), 32'h0C01);

    // 3: start held high, new operands presented on each accept cycle
    fq2.delete();
    repeat (3) @(negedge clock);
    addr = held[0].a; data = held[0].d; start2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wait_busy(2, 1'b1, "held_start");
      addr = 8'hEE; data = 8'h55;
      wait_busy(2, 1'b0, "held_end");
      check("held_done_with_accept", 32'(bus2.done), 32'd1);
      if (i < 2) begin
        addr = held[i+1].a; data = held[i+1].d;
      end else begin
        start2 = 1'b0;
      end
    end
    repeat (3) @(negedge clock);
    check("held_idle", 32'(bus2.busy), 32'd0);
    check("held_count", 32'(fq2.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < fq2.size()) check($sformatf("held_word%0d", i), 32'(fq2[i]), 32'(held[i].exp));

    // 4: start pulse during a frame is ignored
    fq2.delete();
    @(negedge clock);
    addr = 8'h0B; data = 8'h07; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    repeat (20) @(negedge clock);
    addr = 8'h01; data = 8'hAA; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    wait_busy(2, 1'b0, "midstart");
    repeat (10) @(negedge clock);
    check("midstart_idle", 32'(bus2.busy), 32'd0);
    check("midstart_count", 32'(fq2.size()), 32'd1);
    if (fq2.size() > 0) check("midstart_word", 32'(fq2[0]), 32'h0B07);

    // 5: asynchronous reset during bit 7, then a clean frame
    @(negedge clock);
    addr = 8'h0C; data = 8'h01; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    repeat (35) @(negedge clock);
    check("midrst_in_frame", 32'(bus2.load), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_load", 32'(bus2.load), 32'd1);
    check("midrst_sck", 32'(bus2.sck), 32'd0);
    check("midrst_busy", 32'(bus2.busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    fq2.delete();
    @(negedge clock);
    send(2, 2, 8'h0C, 8'h01, "postrst");
    check("postrst_count", 32'(fq2.size()), 32'd1);
    if (fq2.size() > 0) check("postrst_word", 32'(fq2[0]), 32'h0C01);

    // 6: CLK_DIV=1, eight digit writes from the table
    fq1.delete();
    for (int i = 0; i < 8; i++) send(1, 1, digits[i].a, digits[i].d, $sformatf("dig%0d", i));
    check("dig_count", 32'(fq1.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < fq1.size()) check($sformatf("dig_word%0d", i), 32'(fq1[i]), 32'(digits[i].exp));

    check("sck_edge_while_load_high", 32'(edge_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
